// File: rtl/uart_tx_fifo_if.sv
// Byte write channel into the UART transmit FIFO.
// The producer (CPU register block) owns valid/data; the FIFO owns ready.
interface uart_tx_fifo_if;
   logic       i_wr_valid;
   logic [7:0] i_wr_data;
   logic       o_wr_ready;

   modport master (
      output i_wr_valid,
      output i_wr_data,
      input  o_wr_ready
   );

   modport slave (
      input  i_wr_valid,
      input  i_wr_data,
      output o_wr_ready
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO.
// Bytes pushed over the write channel are queued and sent LSB-first with one
// start and one stop bit. Frames run back-to-back while the FIFO holds data.
// Level, busy and sticky overflow status are registered for CPU readback.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   uart_tx_fifo_if.slave                 wr,
   input  logic                          i_clr_ovf,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_busy,
   output logic                          o_overflow,
   output logic                          o_tx
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          tx_q;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;

   logic          baud_end;
   logic          fifo_nonempty;
   logic          pop;
   logic          push;
   logic          drop;
   logic          fsm_to_idle;

   // Handshake decode, FIFO next-state and status next-state.
   // NOTE: every signal gets a value on every path before any condition,
   // otherwise the tool infers a latch to hold the old value.
   always_comb begin
      baud_end      = (baud_q == BAUD_LAST);
      fifo_nonempty = (count_q != '0);
      pop           = fifo_nonempty &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));
      // A full FIFO still takes a byte when the head leaves in the same cycle.
      push          = wr.i_wr_valid && ((count_q != DEPTH_C) || pop);
      drop          = wr.i_wr_valid && !push;
      fsm_to_idle   = (state_q == S_STOP) && baud_end && !fifo_nonempty;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A drop wins over a clear landing in the same cycle.
      ovf_d   = drop ? 1'b1 : (i_clr_ovf ? 1'b0 : ovf_q);
      ready_d = (count_d != DEPTH_C);
      busy_d  = pop || ((state_q != S_IDLE) && !fsm_to_idle) || (count_d != '0);
   end

   // Byte storage, written at the tail on every accepted push.
   // NOTE: the storage array is deliberately not reset; the pointers and count
   // define which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr.i_wr_data;
      end
   end

   // FIFO pointers, level and registered status flags.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   // Frame sequencer: baud timing, bit shifting and the registered line level.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               baud_q <= '0;
               tx_q   <= 1'b1;
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  state_q <= S_START;
                  tx_q    <= 1'b0;
               end
            end
            S_START: begin
               if (baud_end) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  state_q   <= S_DATA;
                  tx_q      <= shift_q[0];
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     shift_q   <= shift_q >> 1;
                     bit_idx_q <= bit_idx_q + 1'b1;
                     tx_q      <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (pop) begin
                     // Next byte starts with no idle gap after the stop bit.
                     shift_q <= mem_q[rd_ptr_q];
                     state_q <= S_START;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               baud_q  <= '0;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign wr.o_wr_ready = ready_q;
   assign o_fifo_count  = count_q;
   assign o_busy        = busy_q;
   assign o_overflow    = ovf_q;
   assign o_tx          = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at 10 clocks per bit, 16-entry FIFO.
// Expected bytes go into a scoreboard queue as stimulus is issued; an
// independent line decoder pops and compares each received frame.
module tb_uart_tx_fifo;

   localparam int NV = 2000;

   logic       clk;
   logic       resetn;
   logic       clr_ovf;
   logic [4:0] fifo_count;
   logic       busy;
   logic       overflow;
   logic       tx;

   uart_tx_fifo_if wr_if ();

   uart_tx_fifo #(
      .CLK_FREQ   (1000000),
      .BAUD_RATE  (100000),
      .FIFO_DEPTH (16)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .wr           (wr_if),
      .i_clr_ovf    (clr_ovf),
      .o_fifo_count (fifo_count),
      .o_busy       (busy),
      .o_overflow   (overflow),
      .o_tx         (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_mis = 0;
   logic [7:0] sb [$];
   bit         mon_ignore = 1'b0;

   // Per-cycle stimulus vectors and sampled outputs (cycle 0 = first run cycle).
   logic       v_valid [NV];
   logic [7:0] v_data  [NV];
   logic       v_clr   [NV];
   logic       s_tx    [NV];
   logic       s_busy  [NV];
   logic       s_ready [NV];
   logic       s_ovf   [NV];
   logic [4:0] s_count [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_vec();
      for (int i = 0; i < NV; i++) begin
         v_valid[i] = 1'b0;
         v_data[i]  = 8'h00;
         v_clr[i]   = 1'b0;
      end
   endtask

   task automatic run_vec(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         wr_if.i_wr_valid = v_valid[c];
         wr_if.i_wr_data  = v_data[c];
         clr_ovf          = v_clr[c];
         @(negedge clk);
         s_tx[c]    = tx;
         s_busy[c]  = busy;
         s_ready[c] = wr_if.o_wr_ready;
         s_ovf[c]   = overflow;
         s_count[c] = fifo_count;
      end
      wr_if.i_wr_valid = 1'b0;
      clr_ovf          = 1'b0;
   endtask

   // Line decoder: samples mid-bit at 10 clk/bit and checks against the scoreboard.
   initial begin : monitor
      logic [7:0] rx;
      logic       start_mid;
      logic       stop_bit;
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && tx === 1'b0) begin
            repeat (5) @(negedge clk);
            start_mid = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (10) @(negedge clk);
               rx[i] = tx;
            end
            repeat (10) @(negedge clk);
            stop_bit = tx;
            if (!mon_ignore) begin
               check("frame_start_stop", {30'd0, start_mid, stop_bit}, 32'd1);
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_mis++;
                  $display("FAIL unexpected_frame: got %02h, expected no frame", rx);
               end else begin
                  check("frame_data", {24'd0, rx}, {24'd0, sb.pop_front()});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] b;
      int         pushes;
      int         gap;
      int         maxc;
      int         cyc;

      resetn           = 1'b0;
      clr_ovf          = 1'b0;
      wr_if.i_wr_valid = 1'b0;
      wr_if.i_wr_data  = 8'h00;
      clear_vec();
      repeat (3) @(negedge clk);
      check("rst_tx",    {31'd0, tx}, 32'd1);
      check("rst_ready", {31'd0, wr_if.o_wr_ready}, 32'd1);
      check("rst_count", {27'd0, fifo_count}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_ovf",   {31'd0, overflow}, 32'd0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      // 1: single byte 0xA5, exact frame timing.
      clear_vec();
      v_valid[0] = 1'b1; v_data[0] = 8'hA5;
      sb.push_back(8'hA5);
      run_vec(110);
      check("t1_idle_c1",  {31'd0, s_tx[1]}, 32'd1);
      check("t1_count_c1", {27'd0, s_count[1]}, 32'd1);
      check("t1_busy_c1",  {31'd0, s_busy[1]}, 32'd1);
      check("t1_count_c2", {27'd0, s_count[2]}, 32'd0);
      check("t1_start_c2", {31'd0, s_tx[2]}, 32'd0);
      check("t1_start_c11",{31'd0, s_tx[11]}, 32'd0);
      b = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t1_bit%0d_first", i), {31'd0, s_tx[12 + 10*i]}, {31'd0, b[i]});
         check($sformatf("t1_bit%0d_mid", i),   {31'd0, s_tx[17 + 10*i]}, {31'd0, b[i]});
      end
      check("t1_stop_c92",  {31'd0, s_tx[92]}, 32'd1);
      check("t1_stop_c101", {31'd0, s_tx[101]}, 32'd1);
      check("t1_busy_c101", {31'd0, s_busy[101]}, 32'd1);
      check("t1_busy_c102", {31'd0, s_busy[102]}, 32'd0);

      // 2: 0x01 then 0x80 back-to-back, no idle gap between frames.
      clear_vec();
      v_valid[0] = 1'b1; v_data[0] = 8'h01;
      v_valid[1] = 1'b1; v_data[1] = 8'h80;
      sb.push_back(8'h01);
      sb.push_back(8'h80);
      run_vec(210);
      check("t2_count_c2",   {27'd0, s_count[2]}, 32'd1);
      check("t2_bit0_c12",   {31'd0, s_tx[12]}, 32'd1);
      check("t2_bit1_c22",   {31'd0, s_tx[22]}, 32'd0);
      check("t2_stop_c101",  {31'd0, s_tx[101]}, 32'd1);
      check("t2_start2_c102",{31'd0, s_tx[102]}, 32'd0);
      check("t2_count_c102", {27'd0, s_count[102]}, 32'd0);
      check("t2_start2_c111",{31'd0, s_tx[111]}, 32'd0);
      check("t2_bit6_c181",  {31'd0, s_tx[181]}, 32'd0);
      check("t2_bit7_c182",  {31'd0, s_tx[182]}, 32'd1);
      check("t2_busy_c201",  {31'd0, s_busy[201]}, 32'd1);
      check("t2_busy_c202",  {31'd0, s_busy[202]}, 32'd0);

      // 3 + 4: 18 consecutive pushes, overflow, clear, push-at-pop when full.
      clear_vec();
      for (int k = 0; k < 18; k++) begin
         v_valid[k] = 1'b1;
         v_data[k]  = 8'h40 + 8'(k);
         if (k < 17) sb.push_back(8'h40 + 8'(k));
      end
      v_clr[19] = 1'b1;
      v_valid[30] = 1'b1; v_data[30] = 8'hEE; v_clr[30] = 1'b1;
      v_clr[32] = 1'b1;
      v_valid[101] = 1'b1; v_data[101] = 8'hC4;
      sb.push_back(8'hC4);
      run_vec(1810);
      check("t3_count_c16", {27'd0, s_count[16]}, 32'd15);
      check("t3_ready_c16", {31'd0, s_ready[16]}, 32'd1);
      check("t3_count_c17", {27'd0, s_count[17]}, 32'd16);
      check("t3_ready_c17", {31'd0, s_ready[17]}, 32'd0);
      check("t3_ovf_c17",   {31'd0, s_ovf[17]}, 32'd0);
      check("t3_ovf_c18",   {31'd0, s_ovf[18]}, 32'd1);
      check("t3_count_c18", {27'd0, s_count[18]}, 32'd16);
      check("t3_ovf_c19",   {31'd0, s_ovf[19]}, 32'd1);
      check("t3_ovf_c20",   {31'd0, s_ovf[20]}, 32'd0);
      check("t3_dropclr_c31", {31'd0, s_ovf[31]}, 32'd1);
      check("t3_ovf_c33",   {31'd0, s_ovf[33]}, 32'd0);
      check("t4_count_c101",{27'd0, s_count[101]}, 32'd16);
      check("t4_count_c102",{27'd0, s_count[102]}, 32'd16);
      check("t4_ovf_c102",  {31'd0, s_ovf[102]}, 32'd0);
      check("t4_ready_c102",{31'd0, s_ready[102]}, 32'd0);
      check("t4_start_c102",{31'd0, s_tx[102]}, 32'd0);
      check("t3_busy_c1801",{31'd0, s_busy[1801]}, 32'd1);
      check("t3_busy_c1802",{31'd0, s_busy[1802]}, 32'd0);
      check("t3_count_c1802",{27'd0, s_count[1802]}, 32'd0);

      // 5: reset during the data phase of 0x55 with three bytes queued.
      mon_ignore = 1'b1;
      clear_vec();
      v_valid[0] = 1'b1; v_data[0] = 8'h55;
      v_valid[1] = 1'b1; v_data[1] = 8'h11;
      v_valid[2] = 1'b1; v_data[2] = 8'h22;
      v_valid[3] = 1'b1; v_data[3] = 8'h33;
      run_vec(46);
      check("t5_count_c45", {27'd0, s_count[45]}, 32'd3);
      check("t5_bit3_c45",  {31'd0, s_tx[45]}, 32'd0);
      #2;
      resetn = 1'b0;
      #1;
      check("t5_async_tx",    {31'd0, tx}, 32'd1);
      check("t5_async_count", {27'd0, fifo_count}, 32'd0);
      check("t5_async_busy",  {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      repeat (150) @(negedge clk);
      mon_ignore = 1'b0;
      clear_vec();
      run_vec(300);
      b = 8'h00;
      for (int c = 0; c < 300; c++) begin
         if (s_tx[c] !== 1'b1 || s_busy[c] !== 1'b0) b = 8'h01;
      end
      check("t5_line_idle_after_reset", {24'd0, b}, 32'd0);

      // 6: random bytes with random gaps, gated on ready so nothing drops.
      pushes = 0;
      gap    = 0;
      maxc   = 0;
      cyc    = 0;
      while (pushes < 250 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
         if (gap == 0 && wr_if.o_wr_ready === 1'b1) begin
            b = 8'($urandom);
            wr_if.i_wr_valid = 1'b1;
            wr_if.i_wr_data  = b;
            sb.push_back(b);
            pushes++;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 150)) : 0;
         end else begin
            wr_if.i_wr_valid = 1'b0;
            if (gap > 0) gap--;
         end
      end
      @(negedge clk);
      wr_if.i_wr_valid = 1'b0;
      check("t6_pushes_issued", pushes, 250);
      cyc = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      end
      check("t6_drain_in_time", {31'd0, cyc < 40000}, 32'd1);
      check("t6_max_count_le16", {31'd0, maxc <= 16}, 32'd1);
      check("t6_no_overflow", {31'd0, overflow}, 32'd0);
      check("sb_empty", sb.size(), 0);
      check("final_tx_idle", {31'd0, tx}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
